// File: rtl/gcd_drv_pkg.sv
// Shared types and helpers for the GCD driver.
// State encoding plus FIFO pointer sizing.
package gcd_drv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  // One extra pointer bit tells full from empty.
  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gcd_drv_fifo.sv
// Vector FIFO for the GCD driver.
// DEPTH entries, combinational head, wrap-bit pointers.
module gcd_drv_fifo
  import gcd_drv_pkg::*;
#(
  parameter int DW    = 384,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            din_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [ptr_w(DEPTH)-1:0]  count_o,
  output logic [DW-1:0]            head_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Pointer update; a refused push or an empty pop is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + PW'(1);
      if (pop_i && !empty_o) rd_q <= rd_q + PW'(1);
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/gcd_driver.sv
// Vector initiator and result checker for the GCD unit.
// Optional watchdog: define GCD_DRV_TIMEOUT_EN.
module gcd_driver
  import gcd_drv_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
`ifdef GCD_DRV_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vec_val,
  output logic             vec_rdy,
  input  logic [W-1:0]     vec_A,
  input  logic [W-1:0]     vec_B,
  input  logic [W-1:0]     vec_expected,
  output logic [W-1:0]     operands_bits_A,
  output logic [W-1:0]     operands_bits_B,
  output logic             operands_val,
  input  logic             operands_rdy,
  input  logic [W-1:0]     result_bits_data,
  input  logic             result_val,
  output logic             result_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [W-1:0]     last_fail_data
`ifdef GCD_DRV_TIMEOUT_EN
  , output logic [CNT_W-1:0] timeout_count
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q;
  logic             op_val_q;
  logic             res_rdy_q;
  logic [CNT_W-1:0] pass_q;
  logic [CNT_W-1:0] fail_q;
  logic [W-1:0]     last_q;

  logic             full;
  logic             empty;
  logic [PW-1:0]    count;
  logic [3*W-1:0]   head;
  logic [W-1:0]     head_e;
  logic             push;
  logic             pop;
  logic             op_hs;
  logic             res_hs;
  logic             match;
  logic             to_fire;

  assign push   = vec_val && !full;
  assign op_hs  = (state_q == SEND) && op_val_q && operands_rdy;
  assign res_hs = (state_q == WAIT) && res_rdy_q && result_val;
  assign match  = (result_bits_data == head_e);
  assign pop    = res_hs || to_fire;

  assign {operands_bits_A, operands_bits_B, head_e} = head;

  assign vec_rdy        = !full;
  assign busy           = (state_q != IDLE) || !empty;
  assign operands_val   = op_val_q;
  assign result_rdy     = res_rdy_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign last_fail_data = last_q;

  gcd_drv_fifo #(
    .DW    (3*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({vec_A, vec_B, vec_expected}),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

`ifdef GCD_DRV_TIMEOUT_EN
  logic [31:0]      wd_q;
  logic [CNT_W-1:0] to_q;

  assign to_fire = (state_q == WAIT) && !res_hs &&
                   (wd_q == 32'(TIMEOUT - 1));
  assign timeout_count = to_q;

  // Watchdog: counts WAIT cycles, cleared on entry to WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
      to_q <= '0;
    end else begin
      if (op_hs) wd_q <= '0;
      else if (state_q == WAIT) wd_q <= wd_q + 32'd1;
      if (to_fire && to_q != CMAX) to_q <= to_q + CNT_W'(1);
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Transaction FSM with registered handshake outputs and checker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_val_q  <= 1'b0;
      res_rdy_q <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
      last_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q  <= SEND;
            op_val_q <= 1'b1;
          end
        end
        SEND: begin
          if (op_hs) begin
            state_q   <= WAIT;
            op_val_q  <= 1'b0;
            res_rdy_q <= 1'b1;
          end
        end
        WAIT: begin
          if (res_hs) begin
            res_rdy_q <= 1'b0;
            if (match) begin
              if (pass_q != CMAX) pass_q <= pass_q + CNT_W'(1);
            end else begin
              if (fail_q != CMAX) fail_q <= fail_q + CNT_W'(1);
              last_q <= result_bits_data;
            end
            if (count > PW'(1)) begin
              state_q  <= SEND;
              op_val_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (to_fire) begin
            res_rdy_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          op_val_q  <= 1'b0;
          res_rdy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_driver.sv
// Self-checking bench for gcd_driver.
// Behavioural GCD responder plus counting reference model.
module tb_gcd_driver;

  localparam int W     = 128;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef GCD_DRV_TIMEOUT_EN
  localparam int TMO   = 16;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             vec_val;
  logic             vec_rdy;
  logic [W-1:0]     vec_A;
  logic [W-1:0]     vec_B;
  logic [W-1:0]     vec_expected;
  logic [W-1:0]     operands_bits_A;
  logic [W-1:0]     operands_bits_B;
  logic             operands_val;
  logic             operands_rdy;
  logic [W-1:0]     result_bits_data;
  logic             result_val;
  logic             result_rdy;
  logic             busy;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [W-1:0]     last_fail_data;
`ifdef GCD_DRV_TIMEOUT_EN
  logic [CNT_W-1:0] timeout_count;
`endif

  gcd_driver #(
    .W     (W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
`ifdef GCD_DRV_TIMEOUT_EN
    , .TIMEOUT (TMO)
`endif
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .vec_val          (vec_val),
    .vec_rdy          (vec_rdy),
    .vec_A            (vec_A),
    .vec_B            (vec_B),
    .vec_expected     (vec_expected),
    .operands_bits_A  (operands_bits_A),
    .operands_bits_B  (operands_bits_B),
    .operands_val     (operands_val),
    .operands_rdy     (operands_rdy),
    .result_bits_data (result_bits_data),
    .result_val       (result_val),
    .result_rdy       (result_rdy),
    .busy             (busy),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .last_fail_data   (last_fail_data)
`ifdef GCD_DRV_TIMEOUT_EN
    , .timeout_count  (timeout_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int           exp_pass = 0;
  int           exp_fail = 0;
  logic [W-1:0] exp_last = '0;
  logic [2*W-1:0] pushed[$];
  int           ord_idx = 0;
  int           push_cyc = 0;

  // Responder controls and observations.
  bit             op_en = 1'b1;
  bit             rsp_never = 1'b0;
  bit             rsp_flush = 1'b0;
  bit             pulse_tog = 1'b0;
  int             rsp_lat = 8;
  logic [2*W-1:0] issued[$];
  int             res_cycs[$];

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural GCD unit: one job at a time, fixed latency.
  initial begin
    bit             hs_op, hs_res, pend, pulse_seen, pulse_on;
    logic [W-1:0]   oa, ob, rdata;
    int             cnt, hc;
    pend = 0; pulse_seen = 0; pulse_on = 0; cnt = 0; rdata = '0;
    operands_rdy = 1'b0;
    result_val = 1'b0;
    result_bits_data = '0;
    forever begin
      @(posedge clk);
      hs_op  = operands_val && operands_rdy;
      hs_res = result_val && result_rdy;
      oa = operands_bits_A;
      ob = operands_bits_B;
      hc = cyc;
      #1;
      if (hs_op) issued.push_back({oa, ob});
      if (hs_res) res_cycs.push_back(hc);
      if (hs_res || pulse_on) begin
        result_val = 1'b0;
        pulse_on = 0;
      end
      if (rsp_flush) pend = 0;
      if (hs_op) begin
        pend = 1;
        cnt = rsp_lat;
        rdata = gcd_ref(oa, ob);
      end
      if (pulse_tog != pulse_seen) begin
        pulse_seen = pulse_tog;
        result_val = 1'b1;
        result_bits_data = W'(3);
        pulse_on = 1;
      end else if (pend && !rsp_never && !result_val) begin
        if (cnt == 0) begin
          result_val = 1'b1;
          result_bits_data = rdata;
          pend = 0;
        end else begin
          cnt--;
        end
      end
      operands_rdy = op_en && !pend && !result_val;
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e, input bit retire);
    logic [W-1:0] g;
    int n;
    bit ok;
    vec_A = a;
    vec_B = b;
    vec_expected = e;
    vec_val = 1'b1;
    n = 0;
    ok = 0;
    while (!ok && n < 300) begin
      @(posedge clk);
      ok = vec_rdy;
      n++;
    end
    push_cyc = cyc;
    #1 vec_val = 1'b0;
    check("push_accept", W'(ok), W'(1));
    pushed.push_back({a, b});
    if (retire) begin
      g = gcd_ref(a, b);
      if (g == e) exp_pass = sat(exp_pass);
      else begin
        exp_fail = sat(exp_fail);
        exp_last = g;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    check("idle", W'(busy), W'(0));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pass"}, W'(pass_count), W'(exp_pass));
    check({tag, "_fail"}, W'(fail_count), W'(exp_fail));
    check({tag, "_last"}, last_fail_data, exp_last);
  endtask

  task automatic check_order(input string tag);
    check({tag, "_nissued"}, W'(issued.size()), W'(pushed.size()));
    while (ord_idx < issued.size() && ord_idx < pushed.size()) begin
      check({tag, "_order"}, issued[ord_idx][W-1:0], pushed[ord_idx][W-1:0]);
      check({tag, "_orderA"}, issued[ord_idx][2*W-1:W],
            pushed[ord_idx][2*W-1:W]);
      ord_idx++;
    end
  endtask

  initial begin
    int n, n0;
    logic [W-1:0] a, b, g, k;
    reset = 1'b1;
    vec_val = 1'b0;
    vec_A = '0;
    vec_B = '0;
    vec_expected = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_vec_rdy", W'(vec_rdy), W'(1));
    check("rst_op_val", W'(operands_val), W'(0));
    check("rst_res_rdy", W'(result_rdy), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check_counts("rst");

    // Single passing vector, latency and busy fall.
    rsp_lat = 8;
    @(posedge clk); #1;
    push(W'(27), W'(15), W'(3), 1);
    @(negedge clk);
    check("t1_idle_cycle", W'(operands_val), W'(0));
    check("t1_busy", W'(busy), W'(1));
    @(negedge clk);
    check("t1_send", W'(operands_val), W'(1));
    check("t1_A", operands_bits_A, W'(27));
    check("t1_B", operands_bits_B, W'(15));
    n = 0;
    while (!(result_val && result_rdy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t1_res_hs", W'(result_val && result_rdy), W'(1));
    check("t1_busy_before", W'(busy), W'(1));
    @(negedge clk);
    check("t1_busy_after", W'(busy), W'(0));
    check_counts("t1");

    // Back-to-back vectors, including zero operands.
    @(posedge clk); #1;
    push(W'(40), W'(0), W'(40), 1);
    push(W'(0), W'(7), W'(7), 1);
    wait_idle();
    check_counts("t2");
    check_order("t2");

    // Mismatch records the returned data.
    @(posedge clk); #1;
    push(W'(12), W'(8), W'(5), 1);
    wait_idle();
    check_counts("t3");

    // Full FIFO with operands stalled.
    op_en = 1'b0;
    rsp_lat = 2;
    @(posedge clk); #1;
    push(W'(6), W'(4), W'(2), 1);
    push(W'(9), W'(6), W'(3), 1);
    push(W'(10), W'(4), W'(2), 1);
    push(W'(21), W'(14), W'(7), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_full", W'(vec_rdy), W'(0));
      check("t4_val_held", W'(operands_val), W'(1));
      check("t4_A_stable", operands_bits_A, W'(6));
      check("t4_B_stable", operands_bits_B, W'(4));
    end
    n0 = res_cycs.size();
    @(posedge clk); #1;
    op_en = 1'b1;
    push(W'(25), W'(35), W'(5), 1);
    check("t4_res_before_push", W'(res_cycs.size() > n0), W'(1));
    if (res_cycs.size() > n0)
      check("t4_push_after_res", W'(push_cyc > res_cycs[n0]), W'(1));
    wait_idle();
    check_counts("t4");
    check_order("t4");

    // Reset while waiting for a result.
    rsp_never = 1'b1;
    @(posedge clk); #1;
    push(W'(100), W'(75), W'(25), 0);
    n = 0;
    while (!result_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_wait", W'(result_rdy), W'(1));
    reset = 1'b1;
    rsp_flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_flush = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    exp_last = '0;
    @(negedge clk);
    check("t5_op_val", W'(operands_val), W'(0));
    check("t5_res_rdy", W'(result_rdy), W'(0));
    check("t5_vec_rdy", W'(vec_rdy), W'(1));
    check("t5_busy", W'(busy), W'(0));
    check_counts("t5");
    rsp_never = 1'b0;
    pulse_tog = ~pulse_tog;
    repeat (4) @(negedge clk);
    check("t5_late_busy", W'(busy), W'(0));
    check("t5_late_rdy", W'(result_rdy), W'(0));
    check_counts("t5_late");
    check_order("t5");

`ifdef GCD_DRV_TIMEOUT_EN
    // Watchdog retires a vector that never gets a result.
    rsp_never = 1'b1;
    @(posedge clk); #1;
    push(W'(18), W'(12), W'(6), 0);
    push(W'(35), W'(21), W'(7), 1);
    n = 0;
    while (!result_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (result_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    rsp_never = 1'b0;
    rsp_flush = 1'b1;
    check("t6_wait_cycles", W'(n), W'(TMO));
    check("t6_to_count", W'(timeout_count), W'(1));
    check("t6_idle", W'(operands_val), W'(0));
    @(negedge clk);
    rsp_flush = 1'b0;
    check("t6_send", W'(operands_val), W'(1));
    check("t6_A", operands_bits_A, W'(35));
    wait_idle();
    check_counts("t6");
    check_order("t6");
`endif

    // Random vectors, some with wrong expectations.
    for (int i = 0; i < 40; i++) begin
      k = W'($urandom_range(1, 1000));
      a = W'($urandom);
      b = W'($urandom);
      a = a * k;
      b = b * k;
      if ($urandom_range(0, 9) == 0) a = '0;
      if ($urandom_range(0, 9) == 0) b = '0;
      g = gcd_ref(a, b);
      if ($urandom_range(0, 3) == 0) g = g + W'(1);
      rsp_lat = $urandom_range(0, 4);
      push(a, b, g, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    check_counts("rnd");
    check_order("rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
